// File: rtl/muldiv_sequencer.sv
// Sequences the iterative multiply/divide units: start pulse, bounded wait, HI/LO write.
// Optional feature: define MULDIV_ABORT_EN to add an abort input that cancels START/RUN.
module muldiv_sequencer #(
    parameter int MAX_CYCLES = 40,
    parameter int CNT_W      = 6
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    input  logic [1:0]  cmd_op,
    input  logic [31:0] divisor,
    input  logic        mult_done,
    input  logic        div_done,
`ifdef MULDIV_ABORT_EN
    input  logic        abort,
`endif
    output logic        mult_start,
    output logic        div_start,
    output logic        hi_we,
    output logic        lo_we,
    output logic        hilo_sel,
    output logic        busy,
    output logic        done,
    output logic        div0_exc,
    output logic        timeout_exc,
    output logic        illegal_exc
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE, START, RUN, WRITE, FIN, EXC
    } stateT;

    typedef enum logic [1:0] {
        OP_NONE = 2'b00, OP_MULT = 2'b01, OP_DIV = 2'b10, OP_BAD = 2'b11
    } opT;

    typedef enum logic [1:0] {
        EXC_NONE, EXC_ILLEGAL, EXC_DIV0, EXC_TIMEOUT
    } excT;

    typedef struct packed {
        opT  op;
        excT cause;
    } cmdLatchT;

    stateT            state, stateNext;
    logic [CNT_W-1:0] counter, counterNext;
    cmdLatchT         cmdLatch, cmdLatchNext;
    logic             hiloSelQ, hiloSelNext;
    logic             unitDone;

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            counter  <= '0;
            cmdLatch <= '{op: OP_NONE, cause: EXC_NONE};
            hiloSelQ <= 1'b0;
        end else begin
            state    <= stateNext;
            counter  <= counterNext;
            cmdLatch <= cmdLatchNext;
            hiloSelQ <= hiloSelNext;
        end
    end

    // Only the unit that was actually started is listened to.
    assign unitDone = (cmdLatch.op == OP_MULT) ? mult_done : div_done;

    always_comb begin
        stateNext    = state;
        counterNext  = counter;
        cmdLatchNext = cmdLatch;
        hiloSelNext  = hiloSelQ;
        mult_start   = 1'b0;
        div_start    = 1'b0;
        hi_we        = 1'b0;
        lo_we        = 1'b0;
        done         = 1'b0;
        div0_exc     = 1'b0;
        timeout_exc  = 1'b0;
        illegal_exc  = 1'b0;

        case (state)
            IDLE: begin
                if (cmd_valid) begin
                    cmdLatchNext.op    = opT'(cmd_op);
                    cmdLatchNext.cause = EXC_NONE;
                    hiloSelNext        = (cmd_op == OP_DIV);
                    case (opT'(cmd_op))
                        OP_MULT: stateNext = START;
                        OP_DIV: begin
                            // A zero divisor never reaches the divide unit.
                            if (divisor == 32'd0) begin
                                cmdLatchNext.cause = EXC_DIV0;
                                stateNext          = EXC;
                            end else begin
                                stateNext = START;
                            end
                        end
                        default: begin
                            cmdLatchNext.cause = EXC_ILLEGAL;
                            stateNext          = EXC;
                        end
                    endcase
                end
            end

            START: begin
                mult_start  = (cmdLatch.op == OP_MULT);
                div_start   = (cmdLatch.op == OP_DIV);
                counterNext = '0;
                stateNext   = RUN;
            end

            RUN: begin
                if (counter != CNT_LAST) begin
                    counterNext = counter + 1'b1;
                end
                // A result arriving on the final allowed cycle still counts.
                if (unitDone) begin
                    stateNext = WRITE;
                end else if (counter == CNT_LAST) begin
                    cmdLatchNext.cause = EXC_TIMEOUT;
                    stateNext          = EXC;
                end
            end

            WRITE: begin
                hi_we     = 1'b1;
                lo_we     = 1'b1;
                stateNext = FIN;
            end

            FIN: begin
                done      = 1'b1;
                stateNext = IDLE;
            end

            EXC: begin
                div0_exc    = (cmdLatch.cause == EXC_DIV0);
                timeout_exc = (cmdLatch.cause == EXC_TIMEOUT);
                illegal_exc = (cmdLatch.cause == EXC_ILLEGAL);
                stateNext   = IDLE;
            end

            default: stateNext = IDLE;
        endcase

`ifdef MULDIV_ABORT_EN
        if (abort && (state == START || state == RUN)) begin
            stateNext = IDLE;
        end
`endif
    end

    assign busy     = (state != IDLE);
    assign hilo_sel = hiloSelQ;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Scoreboard bench for muldiv_sequencer: stimulus queues timestamped expected events,
// a negedge monitor pops and compares every output event the DUT produces.
module tb_muldiv_sequencer;

    localparam int EV_ZERO = 0;
    localparam int EV_BUP  = 1;
    localparam int EV_MST  = 2;
    localparam int EV_DST  = 3;
    localparam int EV_WR   = 4;
    localparam int EV_DONE = 5;
    localparam int EV_DIV0 = 6;
    localparam int EV_TMO  = 7;
    localparam int EV_ILL  = 8;
    localparam int EV_BDN  = 9;

    typedef struct {
        int         cyc;
        int         kind;
        logic [2:0] aux;
    } evT;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cmd_valid = 1'b0;
    logic [1:0]  cmd_op = 2'b00;
    logic [31:0] divisor = 32'd0;
    logic        mult_done = 1'b0;
    logic        div_done = 1'b0;
`ifdef MULDIV_ABORT_EN
    logic        abort = 1'b0;
`endif
    logic mult_start, div_start, hi_we, lo_we, hilo_sel, busy, done;
    logic div0_exc, timeout_exc, illegal_exc;

    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    bit   monEn = 1'b0;
    bit   endReq = 1'b0;
    bit   endAck = 1'b0;
    logic prevBusy = 1'b0;
    evT   q[$];

    muldiv_sequencer #(.MAX_CYCLES(40), .CNT_W(6)) dut (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_op(cmd_op),
        .divisor(divisor), .mult_done(mult_done), .div_done(div_done),
`ifdef MULDIV_ABORT_EN
        .abort(abort),
`endif
        .mult_start(mult_start), .div_start(div_start), .hi_we(hi_we), .lo_we(lo_we),
        .hilo_sel(hilo_sel), .busy(busy), .done(done), .div0_exc(div0_exc),
        .timeout_exc(timeout_exc), .illegal_exc(illegal_exc)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic string evName(int k);
        case (k)
            EV_ZERO: return "all_zero";
            EV_BUP:  return "busy_rise";
            EV_MST:  return "mult_start";
            EV_DST:  return "div_start";
            EV_WR:   return "hilo_write";
            EV_DONE: return "done";
            EV_DIV0: return "div0_exc";
            EV_TMO:  return "timeout_exc";
            EV_ILL:  return "illegal_exc";
            EV_BDN:  return "busy_fall";
            default: return "unknown";
        endcase
    endfunction

    task automatic push(int c, int k, logic [2:0] aux);
        evT e;
        e.cyc = c; e.kind = k; e.aux = aux;
        q.push_back(e);
    endtask

    task automatic check(int k, logic [2:0] aux);
        evT e;
        checks++;
        if (q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_%s cyc=%0d actual=seen aux=%b required=no event", evName(k), cyc, aux);
        end else begin
            e = q.pop_front();
            if (e.kind != k || e.cyc != cyc || e.aux != aux) begin
                failures++;
                $display("FAIL %s actual=%s@%0d aux=%b required=%s@%0d aux=%b",
                         evName(e.kind), evName(k), cyc, aux, evName(e.kind), e.cyc, e.aux);
            end
        end
    endtask

    // Monitor: within one cycle events are compared in a fixed order, which the
    // stimulus mirrors when it queues several events for the same cycle.
    initial begin
        forever begin
            @(negedge clk);
            if (monEn) begin
                while (q.size() > 0 && q[0].cyc < cyc) begin
                    checks++;
                    failures++;
                    $display("FAIL missed_%s actual=absent required=cyc %0d", evName(q[0].kind), q[0].cyc);
                    void'(q.pop_front());
                end
                if (q.size() > 0 && q[0].kind == EV_ZERO && q[0].cyc == cyc) begin
                    void'(q.pop_front());
                    checks++;
                    if ({mult_start, div_start, hi_we, lo_we, hilo_sel, busy, done,
                         div0_exc, timeout_exc, illegal_exc} != 10'd0) begin
                        failures++;
                        $display("FAIL all_zero cyc=%0d actual=%b required=0000000000", cyc,
                                 {mult_start, div_start, hi_we, lo_we, hilo_sel, busy, done,
                                  div0_exc, timeout_exc, illegal_exc});
                    end
                end
                if (busy && !prevBusy)  check(EV_BUP, 3'b000);
                if (mult_start)         check(EV_MST, 3'b000);
                if (div_start)          check(EV_DST, 3'b000);
                if (hi_we || lo_we)     check(EV_WR, {hi_we, lo_we, hilo_sel});
                if (done)               check(EV_DONE, 3'b000);
                if (div0_exc)           check(EV_DIV0, 3'b000);
                if (timeout_exc)        check(EV_TMO, 3'b000);
                if (illegal_exc)        check(EV_ILL, 3'b000);
                if (!busy && prevBusy)  check(EV_BDN, 3'b000);
                prevBusy = busy;
                if (endReq && !endAck) begin
                    checks++;
                    if (q.size() != 0) begin
                        failures++;
                        $display("FAIL leftover_events actual=%0d required=0 (first %s@%0d)",
                                 q.size(), evName(q[0].kind), q[0].cyc);
                    end
                    endAck = 1'b1;
                end
            end
        end
    end

    task automatic waitTo(int c);
        while (cyc < c) @(negedge clk);
    endtask

    // MULT whose unit answers on RUN cycle k (accept cycle a, START a+1, RUN a+2..).
    task automatic doMult(int k, logic [2:0] wrAux);
        int a;
        a = cyc;
        cmd_valid = 1'b1; cmd_op = 2'b01; divisor = 32'd0;
        push(a + 1, EV_BUP, 3'b000);
        push(a + 1, EV_MST, 3'b000);
        push(a + 2 + k, EV_WR, wrAux);
        push(a + 3 + k, EV_DONE, 3'b000);
        push(a + 4 + k, EV_BDN, 3'b000);
        waitTo(a + 1); cmd_valid = 1'b0;
        waitTo(a + 1 + k); mult_done = 1'b1;
        waitTo(a + 2 + k); mult_done = 1'b0;
        waitTo(a + 5 + k);
    endtask

    // One-cycle exception paths: EXC on the cycle after accept, IDLE after that.
    task automatic doExc(logic [1:0] op, logic [31:0] dv, int kind);
        int a;
        a = cyc;
        cmd_valid = 1'b1; cmd_op = op; divisor = dv;
        push(a + 1, EV_BUP, 3'b000);
        push(a + 1, kind, 3'b000);
        push(a + 2, EV_BDN, 3'b000);
        waitTo(a + 1); cmd_valid = 1'b0;
        waitTo(a + 3);
    endtask

    // DIV answering on RUN cycle k; k == 0 means never, giving a timeout after 40 RUN cycles.
    task automatic doDiv(int k);
        int a;
        a = cyc;
        cmd_valid = 1'b1; cmd_op = 2'b10; divisor = 32'd7;
        push(a + 1, EV_BUP, 3'b000);
        push(a + 1, EV_DST, 3'b000);
        if (k == 0) begin
            push(a + 42, EV_TMO, 3'b000);
            push(a + 43, EV_BDN, 3'b000);
        end else begin
            push(a + 2 + k, EV_WR, 3'b111);
            push(a + 3 + k, EV_DONE, 3'b000);
            push(a + 4 + k, EV_BDN, 3'b000);
        end
        waitTo(a + 1); cmd_valid = 1'b0;
        if (k != 0) begin
            waitTo(a + 1 + k); div_done = 1'b1;
            waitTo(a + 2 + k); div_done = 1'b0;
        end
        waitTo(a + 46);
    endtask

    initial begin
        int t;
        repeat (3) @(negedge clk);
        t = cyc;
        push(t + 1, EV_ZERO, 3'b000);
        push(t + 2, EV_ZERO, 3'b000);
        monEn = 1'b1;
        waitTo(t + 2); reset = 1'b0;
        waitTo(t + 4);

        // MULT, done on RUN cycle 3, with a DIV command held during busy that must be ignored.
        t = cyc;
        cmd_valid = 1'b1; cmd_op = 2'b01; divisor = 32'd0;
        push(t + 1, EV_BUP, 3'b000);
        push(t + 1, EV_MST, 3'b000);
        push(t + 5, EV_WR, 3'b110);
        push(t + 6, EV_DONE, 3'b000);
        push(t + 7, EV_BDN, 3'b000);
        waitTo(t + 1); cmd_op = 2'b10;
        waitTo(t + 4); cmd_valid = 1'b0; mult_done = 1'b1;
        waitTo(t + 5); mult_done = 1'b0;
        waitTo(t + 9);

        doExc(2'b10, 32'd0, EV_DIV0);
        doExc(2'b11, 32'd5, EV_ILL);
        doExc(2'b00, 32'd5, EV_ILL);
        doMult(1, 3'b110);
        doDiv(0);
        doDiv(40);
        doDiv(2);
        doMult(2, 3'b110);

        // Reset during RUN of a DIV: everything (including hilo_sel) clears, late dones are ignored.
        t = cyc;
        cmd_valid = 1'b1; cmd_op = 2'b10; divisor = 32'd5;
        push(t + 1, EV_BUP, 3'b000);
        push(t + 1, EV_DST, 3'b000);
        push(t + 4, EV_ZERO, 3'b000);
        push(t + 4, EV_BDN, 3'b000);
        waitTo(t + 1); cmd_valid = 1'b0;
        waitTo(t + 3); reset = 1'b1;
        waitTo(t + 4); reset = 1'b0;
        waitTo(t + 6); div_done = 1'b1; mult_done = 1'b1;
        waitTo(t + 8); div_done = 1'b0; mult_done = 1'b0;
        waitTo(t + 10);
        doMult(3, 3'b110);

`ifdef MULDIV_ABORT_EN
        // Abort on RUN cycle 2: straight back to IDLE with no write, done or exception.
        t = cyc;
        cmd_valid = 1'b1; cmd_op = 2'b01;
        push(t + 1, EV_BUP, 3'b000);
        push(t + 1, EV_MST, 3'b000);
        push(t + 4, EV_BDN, 3'b000);
        waitTo(t + 1); cmd_valid = 1'b0;
        waitTo(t + 3); abort = 1'b1;
        waitTo(t + 4); abort = 1'b0;
        waitTo(t + 5); mult_done = 1'b1;
        waitTo(t + 6); mult_done = 1'b0;
        waitTo(t + 9);
        doMult(1, 3'b110);
`endif

        waitTo(cyc + 3);
        endReq = 1'b1;
        for (int i = 0; i < 10 && !endAck; i++) @(negedge clk);
        if (!endAck) begin
            $display("FAIL end_handshake actual=no ack required=ack");
            $fatal(1, "monitor did not acknowledge end of run");
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
